// File: rtl/memory_responder_if.sv
// Core RAM bus plus byte-stream loader port, as seen between the core/loader
// side (master) and the memory responder (slave).
interface memory_responder_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] data_to_ram;
  logic              web;
  logic [DATA_W-1:0] data_from_ram;

  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_last;
  logic              load_ready;

  modport slave (
    input  ram_address, data_to_ram, web,
    input  load_valid, load_data, load_last,
    output data_from_ram, load_ready
  );

  modport master (
    output ram_address, data_to_ram, web,
    output load_valid, load_data, load_last,
    input  data_from_ram, load_ready
  );
endinterface

// File: rtl/memory_responder.sv
// RAM responder: loads a program image byte-by-byte after reset, then serves
// core reads/writes to a word array and a small memory-mapped I/O window.
module memory_responder #(
  parameter int              ADDR_W    = 15,
  parameter int              DATA_W    = 16,
  parameter logic [ADDR_W-1:0] LOAD_BASE = 15'd9216,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 15'h7FF0
) (
  input  logic              clk,
  input  logic              reset,
  memory_responder_if.slave bus,
  output logic              core_run,
  output logic              load_overflow,
  output logic [DATA_W-1:0] led_out
);

  typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;

  localparam logic [ADDR_W-1:0] CNT_LO_ADDR = MMIO_BASE;
  localparam logic [ADDR_W-1:0] CNT_HI_ADDR = MMIO_BASE + ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LED_ADDR    = MMIO_BASE + ADDR_W'(8);

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [7:0]        hi_q;
  logic              load_ready_q;
  logic              core_run_q;
  logic              overflow_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] led_q;
  logic [31:0]       cnt_q;
  logic [DATA_W-1:0] shadow_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              xfer;
  logic              ptr_in_range;
  logic              in_array;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign xfer         = bus.load_valid && load_ready_q && !reset;
  assign ptr_in_range = ptr_q < MMIO_BASE;
  assign in_array     = bus.ram_address < MMIO_BASE;

  // Single array write port, shared by the loader and the core.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    mem_we    = 1'b0;
    mem_addr  = ptr_q;
    mem_wdata = {bus.load_data, 8'h00};
    if (!reset) begin
      case (state_q)
        LOAD_HI: mem_we = xfer && bus.load_last && ptr_in_range;
        LOAD_LO: begin
          mem_wdata = {hi_q, bus.load_data};
          mem_we    = xfer && ptr_in_range;
        end
        RUN: begin
          mem_addr  = bus.ram_address;
          mem_wdata = bus.data_to_ram;
          mem_we    = bus.web && in_array;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM and survives reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // NOTE: all state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD_HI;
      ptr_q        <= LOAD_BASE;
      hi_q         <= '0;
      load_ready_q <= 1'b0;
      core_run_q   <= 1'b0;
      overflow_q   <= 1'b0;
      rdata_q      <= '0;
      led_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
    end else begin
      case (state_q)
        LOAD_HI: begin
          load_ready_q <= 1'b1;
          rdata_q      <= '0;
          if (xfer) begin
            hi_q <= bus.load_data;
            if (bus.load_last) begin
              state_q      <= RUN;
              load_ready_q <= 1'b0;
              core_run_q   <= 1'b1;
              if (!ptr_in_range) overflow_q <= 1'b1;
            end else begin
              state_q <= LOAD_LO;
            end
          end
        end
        LOAD_LO: begin
          load_ready_q <= 1'b1;
          rdata_q      <= '0;
          if (xfer) begin
            // Pointer parks at MMIO_BASE; further words are dropped, never wrapped.
            if (ptr_in_range) ptr_q <= ptr_q + ADDR_W'(1);
            else              overflow_q <= 1'b1;
            if (bus.load_last) begin
              state_q      <= RUN;
              load_ready_q <= 1'b0;
              core_run_q   <= 1'b1;
            end else begin
              state_q <= LOAD_HI;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 32'd1;
          if (in_array) begin
            rdata_q <= mem[bus.ram_address];
          end else begin
            rdata_q <= '0;
            case (bus.ram_address)
              CNT_LO_ADDR: begin
                rdata_q  <= cnt_q[15:0];
                shadow_q <= cnt_q[31:16];
              end
              CNT_HI_ADDR: rdata_q <= shadow_q;
              LED_ADDR:    rdata_q <= led_q;
              default:     ;
            endcase
            if (bus.web) begin
              // Clearing the counter overrides this cycle's increment.
              case (bus.ram_address)
                CNT_LO_ADDR: cnt_q <= '0;
                LED_ADDR:    led_q <= bus.data_to_ram;
                default:     ;
              endcase
            end
          end
        end
        default: state_q <= LOAD_HI;
      endcase
    end
  end

  assign bus.data_from_ram = rdata_q;
  assign bus.load_ready    = load_ready_q;
  assign core_run          = core_run_q;
  assign load_overflow     = overflow_q;
  assign led_out           = led_q;

endmodule
